// File: rtl/rise_edge_pkg.sv
// Shared types and helpers for the rising-edge pulse scheduler.
//  - state_e : scheduler FSM encoding (IDLE, PULSE, GAP)
//  - GAP_W   : width of the inter-pulse gap counter (covers MIN_GAP up to 255)
//  - clog2   : ceiling log2, used to size channel indices
package rise_edge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int unsigned GAP_W = 8;

   // Smallest r with 2**r >= value.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting one position after the last granted
// index, wrapping around, and reports the first requester found.
// Ports:
//  req_i          in   N_CH          request flags
//  last_i         in   clog2(N_CH)   index granted most recently
//  grant_valid_o  out  1             at least one request present
//  grant_idx_o    out  clog2(N_CH)   selected index (0 when none)
module rr_arbiter
   import rise_edge_pkg::*;
#(
   parameter int unsigned N_CH = 4
) (
   input  logic [N_CH-1:0]        req_i,
   input  logic [clog2(N_CH)-1:0] last_i,
   output logic                   grant_valid_o,
   output logic [clog2(N_CH)-1:0] grant_idx_o
);

   localparam int unsigned CH_W = clog2(N_CH);

   logic [CH_W-1:0] cand;

   // Walk last+1 .. last+N_CH (mod N_CH); the first hit wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      cand          = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = CH_W'((32'(last_i) + k) % N_CH);
         if (!grant_valid_o && req_i[cand]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/rise_edge_pulse_scheduler.sv
// Shares one output pulse line among N_CH pulse-input channels.
// Rising edges on each channel are queued as pending requests, granted
// round-robin, and each grant emits one OUT_PULSE of IN_LENGTH cycles
// (0 treated as 1) tagged with the channel number. At least MIN_GAP low
// cycles separate consecutive output pulses.
// Ports:
//  IN_CLOCK      in   1             clock, all state changes on rising edge
//  IN_RESET      in   1             synchronous active-high reset
//  IN_PULSE      in   N_CH          pre-synchronised channel levels
//  IN_LENGTH     in   LEN_W         pulse length, sampled at grant
//  OUT_PULSE     out  1             shared output pulse
//  OUT_CHANNEL   out  clog2(N_CH)   channel owning the current/last pulse
//  OUT_BUSY      out  1             scheduler not idle
//  OUT_PENDING   out  N_CH          pending request flags
//  OUT_OVERFLOW  out  1             edge coalesced into an already-pending request
module rise_edge_pulse_scheduler
   import rise_edge_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MIN_GAP = 1
) (
   input  logic                   IN_CLOCK,
   input  logic                   IN_RESET,
   input  logic [N_CH-1:0]        IN_PULSE,
   input  logic [LEN_W-1:0]       IN_LENGTH,
   output logic                   OUT_PULSE,
   output logic [clog2(N_CH)-1:0] OUT_CHANNEL,
   output logic                   OUT_BUSY,
   output logic [N_CH-1:0]        OUT_PENDING,
   output logic                   OUT_OVERFLOW
);

   localparam int unsigned       CH_W     = clog2(N_CH);
   localparam logic [CH_W-1:0]   LAST_RST = CH_W'(N_CH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MIN_GAP - 1);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CH_W-1:0]   last_q, last_d;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic [N_CH-1:0]   prev_q;
   logic [N_CH-1:0]   pending_q, pending_d;
   logic              overflow_q, overflow_d;

   logic [N_CH-1:0]   edge_c;
   logic [N_CH-1:0]   clear_c;
   logic              arb_en_c;
   logic              grant_valid_c;
   logic [CH_W-1:0]   grant_idx_c;

   // Rising-edge detect against the previous-cycle level.
   assign edge_c = IN_PULSE & ~prev_q;

   // Arbitrate while idle, or on the last gap cycle so the next pulse
   // follows after exactly MIN_GAP low cycles.
   assign arb_en_c = (state_q == ST_IDLE) ||
                     ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST));

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .req_i         (pending_q),
      .last_i        (last_q),
      .grant_valid_o (grant_valid_c),
      .grant_idx_o   (grant_idx_c)
   );

   // Next-state, counters, grant bookkeeping and pending update.
   always_comb begin
      state_d    = state_q;
      len_cnt_d  = len_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      last_d     = last_q;
      chan_d     = chan_q;
      clear_c    = '0;
      pending_d  = pending_q;
      overflow_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_PULSE: begin
            len_cnt_d = len_cnt_q - LEN_ONE;
            if (len_cnt_q == LEN_ONE) begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A grant overrides the IDLE fallback at the end of a gap.
      if (arb_en_c && grant_valid_c) begin
         clear_c[grant_idx_c] = 1'b1;
         last_d               = grant_idx_c;
         chan_d               = grant_idx_c;
         len_cnt_d            = (IN_LENGTH == '0) ? LEN_ONE : IN_LENGTH;
         state_d              = ST_PULSE;
      end

      // Set wins over clear: an edge on the channel being granted re-queues it.
      pending_d  = edge_c | (pending_q & ~clear_c);
      overflow_d = |(edge_c & pending_q & ~clear_c);
   end

   // State and output registers.
   always_ff @(posedge IN_CLOCK) begin
      if (IN_RESET) begin
         state_q    <= ST_IDLE;
         len_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         last_q     <= LAST_RST;
         chan_q     <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         prev_q     <= IN_PULSE;
      end else begin
         state_q    <= state_d;
         len_cnt_q  <= len_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         last_q     <= last_d;
         chan_q     <= chan_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         prev_q     <= IN_PULSE;
      end
   end

   assign OUT_PULSE    = (state_q == ST_PULSE);
   assign OUT_BUSY     = (state_q != ST_IDLE);
   assign OUT_CHANNEL  = chan_q;
   assign OUT_PENDING  = pending_q;
   assign OUT_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_rise_edge_pulse_scheduler.sv
// Testbench for rise_edge_pulse_scheduler (N_CH=4, LEN_W=8, MIN_GAP=2).
module tb_rise_edge_pulse_scheduler;

   localparam int N_CH    = 4;
   localparam int LEN_W   = 8;
   localparam int MIN_GAP = 2;

   logic       clk;
   logic       rst;
   logic [3:0] pulse_in;
   logic [7:0] len;
   logic       out_pulse;
   logic [1:0] out_ch;
   logic       busy;
   logic [3:0] pend;
   logic       ovf;

   int checks   = 0;
   int failures = 0;

   rise_edge_pulse_scheduler #(
      .N_CH    (N_CH),
      .LEN_W   (LEN_W),
      .MIN_GAP (MIN_GAP)
   ) dut (
      .IN_CLOCK     (clk),
      .IN_RESET     (rst),
      .IN_PULSE     (pulse_in),
      .IN_LENGTH    (len),
      .OUT_PULSE    (out_pulse),
      .OUT_CHANNEL  (out_ch),
      .OUT_BUSY     (busy),
      .OUT_PENDING  (pend),
      .OUT_OVERFLOW (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model: timestamps of grants instead of an explicit FSM.
   // A grant at clock t drives the pulse for clocks t..t+L-1 and the next
   // arbitration opportunity is clock t+L+MIN_GAP.
   bit m_pend[N_CH];
   bit m_prev[N_CH];
   int m_t, m_next_arb, m_grant_t, m_len, m_last, m_ch;
   bit m_ovf;

   function automatic bit exp_pulse();
      return (m_t >= m_grant_t) && (m_t < m_grant_t + m_len);
   endfunction

   function automatic bit exp_busy();
      return m_t < m_next_arb;
   endfunction

   function automatic logic [3:0] exp_pend();
      logic [3:0] v;
      for (int i = 0; i < N_CH; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_step();
      int g;
      bit e;
      m_t++;
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = pulse_in[i];
         end
         m_next_arb = m_t;
         m_grant_t  = -1000;
         m_len      = 0;
         m_last     = N_CH - 1;
         m_ch       = 0;
         m_ovf      = 1'b0;
         return;
      end
      g = -1;
      if (m_t >= m_next_arb) begin
         for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (m_last + k) % N_CH;
            if (g < 0 && m_pend[c]) g = c;
         end
         if (g >= 0) begin
            m_last     = g;
            m_ch       = g;
            m_grant_t  = m_t;
            m_len      = (len == 8'd0) ? 1 : int'(len);
            m_next_arb = m_t + m_len + MIN_GAP;
         end
      end
      m_ovf = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         e = pulse_in[i] && !m_prev[i];
         if (e && m_pend[i] && i != g) m_ovf = 1'b1;
         m_pend[i] = e || (m_pend[i] && i != g);
         m_prev[i] = pulse_in[i];
      end
   endtask

   // Observation record of the output waveform.
   int rise_ch[$];
   int rise_tick[$];
   int hi_len[$];
   int lo_len[$];
   int tick_n, ovf_cnt, hi_run, lo_run;
   bit was_hi, seen_fall;

   task automatic obs_clear();
      rise_ch.delete();
      rise_tick.delete();
      hi_len.delete();
      lo_len.delete();
      tick_n    = 0;
      ovf_cnt   = 0;
      hi_run    = 0;
      lo_run    = 0;
      seen_fall = 1'b0;
   endtask

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // One clock: model sees the same inputs as the DUT, outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      tick_n++;
      if (ovf === 1'b1) ovf_cnt++;
      if (out_pulse === 1'b1) begin
         if (!was_hi) begin
            rise_ch.push_back(int'(out_ch));
            rise_tick.push_back(tick_n);
            if (seen_fall) lo_len.push_back(lo_run);
            hi_run = 0;
         end
         hi_run++;
         was_hi = 1'b1;
      end else begin
         if (was_hi) begin
            hi_len.push_back(hi_run);
            seen_fall = 1'b1;
            lo_run    = 0;
         end
         lo_run++;
         was_hi = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(busy === 1'b0 && pend === 4'b0000 && out_pulse === 1'b0) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL %s_idle: busy=%b pend=%b not idle after %0d cycles", name, busy, pend, n);
      end
      tick();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      pulse_in = 4'b0001;
      len      = 8'd1;
      was_hi   = 1'b0;
      tick();
      tick();
      checks++; if (out_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b want 0", out_pulse); end
      checks++; if (out_ch !== 2'd0)    begin failures++; $display("FAIL reset_channel: got %0d want 0", out_ch); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (pend !== 4'b0000)   begin failures++; $display("FAIL reset_pending: got %b want 0000", pend); end
      checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_overflow: got %b want 0", ovf); end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (out_pulse !== 1'b0 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL held_level cycle %0d: pulse=%b pend=%b want 0/0000", i, out_pulse, pend);
         end
      end
      pulse_in = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_single();
      int first_idle;
      wait_idle("single");
      obs_clear();
      len      = 8'd3;
      pulse_in = 4'b0100;
      tick();
      pulse_in = 4'b0000;
      first_idle = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (first_idle < 0 && rise_tick.size() > 0 && busy === 1'b0) first_idle = tick_n;
      end
      checks++; if (rise_tick.size() != 1) begin failures++; $display("FAIL single_count: got %0d pulses want 1", rise_tick.size()); end
      checks++; if (qat(rise_tick, 0) != 2) begin failures++; $display("FAIL single_latency: got %0d want 2", qat(rise_tick, 0)); end
      checks++; if (qat(hi_len, 0) != 3)    begin failures++; $display("FAIL single_width: got %0d want 3", qat(hi_len, 0)); end
      checks++; if (qat(rise_ch, 0) != 2)   begin failures++; $display("FAIL single_channel: got %0d want 2", qat(rise_ch, 0)); end
      checks++; if (first_idle != 7)        begin failures++; $display("FAIL single_busy_drop: got %0d want 7", first_idle); end
   endtask

   task automatic test_rr_order();
      int exp_ch[3] = '{3, 0, 1};
      wait_idle("rr");
      obs_clear();
      len      = 8'd3;
      pulse_in = 4'b1011;
      tick();
      pulse_in = 4'b0000;
      repeat (29) tick();
      checks++; if (rise_ch.size() != 3) begin failures++; $display("FAIL rr_count: got %0d want 3", rise_ch.size()); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (qat(rise_ch, k) != exp_ch[k]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, qat(rise_ch, k), exp_ch[k]); end
         checks++; if (qat(hi_len, k) != 3) begin failures++; $display("FAIL rr_width[%0d]: got %0d want 3", k, qat(hi_len, k)); end
      end
      for (int k = 0; k < 2; k++) begin
         checks++; if (qat(lo_len, k) != MIN_GAP) begin failures++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, qat(lo_len, k), MIN_GAP); end
      end
   endtask

   task automatic test_zero_len();
      wait_idle("zero");
      obs_clear();
      len      = 8'd0;
      pulse_in = 4'b0010;
      tick();
      pulse_in = 4'b0000;
      repeat (11) tick();
      checks++; if (rise_ch.size() != 1)  begin failures++; $display("FAIL zero_count: got %0d want 1", rise_ch.size()); end
      checks++; if (qat(rise_ch, 0) != 1) begin failures++; $display("FAIL zero_channel: got %0d want 1", qat(rise_ch, 0)); end
      checks++; if (qat(hi_len, 0) != 1)  begin failures++; $display("FAIL zero_width: got %0d want 1", qat(hi_len, 0)); end
   endtask

   task automatic test_overflow();
      wait_idle("ovf");
      obs_clear();
      len      = 8'd5;
      pulse_in = 4'b0001; tick();
      pulse_in = 4'b0000; tick();
      pulse_in = 4'b0010; tick();
      pulse_in = 4'b0000; tick();
      pulse_in = 4'b0010; tick();
      pulse_in = 4'b0000;
      repeat (25) tick();
      checks++; if (ovf_cnt != 1)         begin failures++; $display("FAIL ovf_flag_cycles: got %0d want 1", ovf_cnt); end
      checks++; if (rise_ch.size() != 2)  begin failures++; $display("FAIL ovf_pulse_count: got %0d want 2", rise_ch.size()); end
      checks++; if (qat(rise_ch, 0) != 0) begin failures++; $display("FAIL ovf_first_ch: got %0d want 0", qat(rise_ch, 0)); end
      checks++; if (qat(rise_ch, 1) != 1) begin failures++; $display("FAIL ovf_second_ch: got %0d want 1", qat(rise_ch, 1)); end
   endtask

   task automatic test_own_grant();
      int exp_ch[3] = '{0, 1, 1};
      wait_idle("own");
      obs_clear();
      len      = 8'd2;
      pulse_in = 4'b0001; tick();
      pulse_in = 4'b0000; tick();
      pulse_in = 4'b0010; tick();
      pulse_in = 4'b0000; tick(); tick();
      pulse_in = 4'b0010; tick();
      pulse_in = 4'b0000;
      repeat (24) tick();
      checks++; if (rise_ch.size() != 3) begin failures++; $display("FAIL own_count: got %0d want 3", rise_ch.size()); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (qat(rise_ch, k) != exp_ch[k]) begin failures++; $display("FAIL own_order[%0d]: got %0d want %0d", k, qat(rise_ch, k), exp_ch[k]); end
      end
      checks++; if (ovf_cnt != 0)            begin failures++; $display("FAIL own_overflow: got %0d want 0", ovf_cnt); end
      checks++; if (qat(lo_len, 1) != MIN_GAP) begin failures++; $display("FAIL own_gap: got %0d want %0d", qat(lo_len, 1), MIN_GAP); end
   endtask

   task automatic test_mid_reset();
      wait_idle("mrst");
      obs_clear();
      len      = 8'd5;
      pulse_in = 4'b1000; tick();
      pulse_in = 4'b0000; tick();
      checks++; if (out_pulse !== 1'b1 || out_ch !== 2'd3) begin failures++; $display("FAIL mrst_start: pulse=%b ch=%0d want 1/3", out_pulse, out_ch); end
      pulse_in = 4'b0001; tick();
      checks++; if (pend !== 4'b0001 || out_pulse !== 1'b1) begin failures++; $display("FAIL mrst_cycle2: pend=%b pulse=%b want 0001/1", pend, out_pulse); end
      rst      = 1'b1;
      pulse_in = 4'b0000;
      tick();
      checks++; if (out_pulse !== 1'b0) begin failures++; $display("FAIL mrst_pulse: got %b want 0", out_pulse); end
      checks++; if (pend !== 4'b0000)   begin failures++; $display("FAIL mrst_pending: got %b want 0000", pend); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mrst_busy: got %b want 0", busy); end
      rst = 1'b0;
      obs_clear();
      repeat (15) tick();
      checks++; if (rise_ch.size() != 0) begin failures++; $display("FAIL mrst_resume: got %0d pulses want 0", rise_ch.size()); end
   endtask

   task automatic test_random();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N_CH; i++) begin
            if ($urandom_range(0, 2) == 0) pulse_in[i] = ~pulse_in[i];
         end
         len = 8'($urandom_range(0, 6));
         rst = ($urandom_range(0, 149) == 0);
         if (n >= 1480) begin
            pulse_in = 4'b0000;
            rst      = 1'b0;
         end
         tick();
         checks++; if (out_pulse !== exp_pulse())  begin failures++; $display("FAIL rand_pulse t=%0d: got %b want %b", m_t, out_pulse, exp_pulse()); end
         checks++; if (out_ch !== 2'(m_ch))        begin failures++; $display("FAIL rand_channel t=%0d: got %0d want %0d", m_t, out_ch, m_ch); end
         checks++; if (busy !== exp_busy())        begin failures++; $display("FAIL rand_busy t=%0d: got %b want %b", m_t, busy, exp_busy()); end
         checks++; if (pend !== exp_pend())        begin failures++; $display("FAIL rand_pending t=%0d: got %b want %b", m_t, pend, exp_pend()); end
         checks++; if (ovf !== m_ovf)              begin failures++; $display("FAIL rand_overflow t=%0d: got %b want %b", m_t, ovf, m_ovf); end
      end
   endtask

   initial begin
      rst      = 1'b1;
      pulse_in = 4'b0001;
      len      = 8'd1;
      m_t      = 0;
      test_reset();
      test_single();
      test_rr_order();
      test_zero_len();
      test_overflow();
      test_own_grant();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
